// File: rtl/ling16_csum_arbiter.sv
// Round-robin checksum engine: NREQ requesters share one 16-bit
// end-around-carry Ling adder that folds each burst into a one's-complement
// (mod 2^16-1) sum, returned with the requester id and a saturating beat count.

// Ling-recurrence adder with end-around carry. The first pass finds the
// carry-out with no carry-in; the second pass feeds that carry back into
// bit 0. This equals "subtract 0xFFFF when the sum reaches 0x10000", and
// the folded-back carry can never overflow a second time.
module ling16_eac_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] t;
  logic [15:0] x;
  logic [15:0] h0;
  logic [15:0] h1;
  logic [15:0] c;
  logic        cout;

  // Ling pseudo-carries H_i = g_i | t_{i-1} & H_{i-1}; the real carry is t_i & H_i
  always_comb begin
    g    = a & b;
    t    = a | b;
    x    = a ^ b;
    h0   = '0;
    h1   = '0;
    c    = '0;
    h0[0] = g[0];
    for (int i = 1; i < 16; i++) begin
      h0[i] = g[i] | (t[i-1] & h0[i-1]);
    end
    cout  = t[15] & h0[15];
    h1[0] = g[0] | cout;
    for (int i = 1; i < 16; i++) begin
      h1[i] = g[i] | (t[i-1] & h1[i-1]);
    end
    c[0] = cout;
    for (int i = 1; i < 16; i++) begin
      c[i] = t[i-1] & h1[i-1];
    end
    sum = x ^ c;
  end

endmodule

module ling16_csum_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [16*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [15:0]        res_sum,
  output logic [IDW-1:0]     res_id,
  output logic [7:0]         res_beats
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_OUT
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [15:0]    acc;
  logic [7:0]     beats;

  logic [IDW-1:0] next_grant;
  logic [IDW-1:0] cand;
  logic           any_valid;
  logic [15:0]    sel_word;
  logic [15:0]    acc_next;
  logic [7:0]     beats_next;
  logic           beat_fire;

  // Pick the nearest valid requester after ptr, wrapping; scanning from the
  // farthest candidate down lets the nearest one overwrite the others
  always_comb begin
    next_grant = '0;
    any_valid  = 1'b0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        next_grant = cand;
        any_valid  = 1'b1;
      end
    end
  end

  // Route the granted requester's word to the shared adder
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_word = req_data[16*i +: 16];
      end
    end
  end

  ling16_eac_adder u_adder (
    .a   (acc),
    .b   (sel_word),
    .sum (acc_next)
  );

  assign beats_next = (beats == 8'hFF) ? beats : beats + 8'd1;
  assign beat_fire  = (state == ST_BUSY) && req_ready[grant] && req_valid[grant];

  // Arbitrate, accumulate the granted burst, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= IDW'(NREQ - 1);
      grant     <= '0;
      acc       <= '0;
      beats     <= '0;
      req_ready <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      res_beats <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant     <= next_grant;
            ptr       <= next_grant;
            acc       <= '0;
            beats     <= '0;
            req_ready <= NREQ'(1) << next_grant;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (beat_fire) begin
            acc   <= acc_next;
            beats <= beats_next;
            if (req_last[grant]) begin
              req_ready <= '0;
              res_valid <= 1'b1;
              res_sum   <= acc_next;
              res_id    <= grant;
              res_beats <= beats_next;
              state     <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          req_ready <= '0;
          res_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
